// File: rtl/grf_pkg.sv
// Shared defaults for the multi-ported register file and the write-trace format.
// Optional trace output is enabled by defining GRF_TRACE_EN.
`ifndef GRF_PKG_SV
`define GRF_PKG_SV

`define GRF_TRACE_FMT "%d@%h: $%d <= %h"

package grf_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_NUM_RD = 2;
  localparam int GRF_NUM_WR = 2;
  localparam int GRF_PC_W   = 32;

endpackage

`endif

// File: rtl/grf_scoreboard.sv
// Busy-bit scoreboard: reserve sets, write clears, set wins; busy and busy_cnt update on the same edge.
// Latency 1 cycle from reserve/write to visible busy; no backpressure, every request is taken.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_WR = GRF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    // Reserve is applied after the clears: the reserving instruction is the newer producer.
    if (rsv_en) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;

    cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-ported register file: NUM_RD combinational read ports with write bypass, NUM_WR prioritised writes, busy scoreboard.
// Reads 0 cycles, writes/busy 1 cycle; no backpressure. Define GRF_TRACE_EN to print committed writes.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = GRF_NUM_RD,
  parameter int NUM_WR = GRF_NUM_WR
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*GRF_PC_W-1:0] wr_pc,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [NUM_WR-1:0] wr_act;

  // Writes to $0 are dropped here so neither storage nor bypass ever sees them.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_act[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Ascending port order: the last assignment (highest index) wins on conflicts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_act[j]) begin
          regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rd = regs[ra];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_act[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
          rd = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (!reset_n || (ra == '0)) begin
        rd = '0;
      end
      rd_data[k*DATA_W +: DATA_W] = rd;
      rd_busy[k] = reset_n && busy[ra];
    end
  end

  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_act),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

`ifdef GRF_TRACE_EN
  logic [NUM_WR-1:0] wr_win;

  always_comb begin
    wr_win = wr_act;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int h = j + 1; h < NUM_WR; h++) begin
        if (wr_act[h] && (wr_addr[h*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
          wr_win[j] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_win[j]) begin
          $display(`GRF_TRACE_FMT, $time, wr_pc[j*GRF_PC_W +: GRF_PC_W],
                   wr_addr[j*ADDR_W +: ADDR_W], wr_data[j*DATA_W +: DATA_W]);
        end
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp: expectations are queued at drive time and popped when outputs are sampled.
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_pc;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [5:0]  busy_cnt;

  always #5 clk = ~clk;

  grf_mp dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_pc    (wr_pc),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h required=queued_entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*5 +: 5]    = a;
    wr_data[p*32 +: 32]  = d;
    wr_pc[p*32 +: 32]    = 32'h0000_1000 + 32'(p * 4);
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    reset_n  = 1'b0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_pc    = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;

    // Power-on reset state
    push("rst_rd0", 64'h0);
    push("rst_busy", 64'h0);
    push("rst_cnt", 64'h0);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    pop_chk(64'(rd_busy));
    pop_chk(64'(busy_cnt));
    cyc();
    reset_n = 1'b1;

    // Same-cycle bypass, then stored value
    wr(0, 5'd3, 32'hDEADBEEF);
    rd_addr[4:0] = 5'd3;
    push("byp_same", 64'hDEADBEEF);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    cyc();
    idle();
    push("byp_next", 64'hDEADBEEF);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    cyc();

    // Port priority on a shared address
    wr(0, 5'd7, 32'h1);
    wr(1, 5'd7, 32'h2);
    rd_addr = {5'd7, 5'd7};
    push("prio_byp0", 64'h2);
    push("prio_byp1", 64'h2);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    pop_chk(64'(rd_data[63:32]));
    cyc();
    idle();
    push("prio_store", 64'h2);
    @(negedge clk);
    pop_chk(64'(rd_data[63:32]));
    cyc();

    // Register 0 ignores writes and reserves
    wr(0, 5'd0, 32'hFFFF);
    rsv(5'd0);
    rd_addr = {5'd7, 5'd0};
    push("r0_byp", 64'h0);
    push("r0_busy_same", 64'h0);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    pop_chk(64'(rd_busy));
    cyc();
    idle();
    push("r0_rd", 64'h0);
    push("r0_busy", 64'h0);
    push("r0_cnt", 64'h0);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    pop_chk(64'(rd_busy));
    pop_chk(64'(busy_cnt));
    cyc();

    // Scoreboard: reserve, write+reserve (set wins), write alone clears
    rsv(5'd9);
    rd_addr = {5'd9, 5'd0};
    push("sb_rsv_same", 64'h0);
    @(negedge clk);
    pop_chk(64'(rd_busy));
    cyc();
    idle();
    wr(0, 5'd9, 32'h99);
    rsv(5'd9);
    push("sb_busy1", 64'h2);
    push("sb_cnt1", 64'h1);
    push("sb_byp99", 64'h99);
    @(negedge clk);
    pop_chk(64'(rd_busy));
    pop_chk(64'(busy_cnt));
    pop_chk(64'(rd_data[63:32]));
    cyc();
    idle();
    wr(1, 5'd9, 32'hAA);
    push("sb_setwins_busy", 64'h2);
    push("sb_setwins_cnt", 64'h1);
    push("sb_bypAA", 64'hAA);
    @(negedge clk);
    pop_chk(64'(rd_busy));
    pop_chk(64'(busy_cnt));
    pop_chk(64'(rd_data[63:32]));
    cyc();
    idle();
    push("sb_clr_busy", 64'h0);
    push("sb_clr_cnt", 64'h0);
    push("sb_storeAA", 64'hAA);
    @(negedge clk);
    pop_chk(64'(rd_busy));
    pop_chk(64'(busy_cnt));
    pop_chk(64'(rd_data[63:32]));
    cyc();

    // Reset mid-operation discards data and reservations
    wr(0, 5'd5, 32'h1234);
    rsv(5'd4);
    rd_addr = {5'd4, 5'd5};
    push("pre_rst_byp", 64'h1234);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    cyc();
    idle();
    push("pre_rst_rd", 64'h1234);
    push("pre_rst_cnt", 64'h1);
    push("pre_rst_busy", 64'h2);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    pop_chk(64'(busy_cnt));
    pop_chk(64'(rd_busy));
    #1;
    reset_n = 1'b0;
    wr(0, 5'd5, 32'h5555);
    rsv(5'd6);
    push("in_rst_rd", 64'h0);
    push("in_rst_busy", 64'h0);
    push("in_rst_cnt", 64'h0);
    #1;
    pop_chk(64'(rd_data[31:0]));
    pop_chk(64'(rd_busy));
    pop_chk(64'(busy_cnt));
    cyc();
    reset_n = 1'b1;
    idle();
    rd_addr = {5'd6, 5'd5};
    push("post_rst_rd5", 64'h0);
    push("post_rst_busy", 64'h0);
    push("post_rst_cnt", 64'h0);
    @(negedge clk);
    pop_chk(64'(rd_data[31:0]));
    pop_chk(64'(rd_busy));
    pop_chk(64'(busy_cnt));
    cyc();

    // Fill the scoreboard one register per cycle
    for (int r = 1; r < 32; r++) begin
      rsv(5'(r));
      push($sformatf("fill_cnt_%0d", r), 64'(r - 1));
      @(negedge clk);
      pop_chk(64'(busy_cnt));
      cyc();
    end
    rsv(5'd31);
    rd_addr = {5'd1, 5'd31};
    push("fill_full_cnt", 64'd31);
    push("fill_full_busy", 64'h3);
    @(negedge clk);
    pop_chk(64'(busy_cnt));
    pop_chk(64'(rd_busy));
    cyc();
    idle();
    push("fill_rersv_cnt", 64'd31);
    @(negedge clk);
    pop_chk(64'(busy_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
